// File: rtl/sim_monitor_pkg.sv
// Shared types for the simulation run monitor.
package sim_monitor_pkg;

    localparam int unsigned TSTAMP_W = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StPass    = 2'd2,
        StTimeout = 2'd3
    } mon_state_e;

endpackage

// File: rtl/sim_monitor_fifo.sv
// Synchronous event FIFO with full/empty flags; read data is 0 while empty.
module sim_monitor_fifo #(
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          wr_en;
    logic          rd_en;

    // Flags and gated enables; a push into a full FIFO is accepted only when a pop frees a slot.
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        wr_en = push && (!full || pop);
        rd_en = pop && !empty;
        rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // Pointer update, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage; contents are masked by the empty flag so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sim_monitor.sv
// Run monitor: change-event queue plus PASS/TIMEOUT watchdog.
// Define SIM_MONITOR_TSTAMP_EN to store a 32-bit RUN-cycle timestamp with each event.
module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int unsigned     WIDTH          = 4,
    parameter int unsigned     FIFO_DEPTH     = 8,
    parameter int unsigned     TIMEOUT_CYCLES = 250,
    parameter logic [WIDTH-1:0] PASS_PATTERN  = '1,
    parameter int unsigned     STABLE_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic [WIDTH-1:0]    watch_i,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [WIDTH-1:0]    evt_value_o,
    output logic [TSTAMP_W-1:0] evt_tstamp_o,
    output logic [1:0]          state_o,
    output logic                done_o,
    output logic                overflow_o
);

    localparam int unsigned    CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned    SW        = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CYC_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0]  STB_LIMIT = SW'(STABLE_CYCLES);

    mon_state_e     state_q;
    logic           done_q;
    logic           overflow_q;
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]  cycle_q;
    logic [SW-1:0]  stable_q;

    logic           in_run;
    logic           is_pass;
    logic [CW-1:0]  cycle_nxt;
    logic [SW-1:0]  stable_nxt;
    logic           pass_hit;
    logic           timeout_hit;
    logic           push;
    logic           pop;
    logic           drop;
    logic           fifo_full;
    logic           fifo_empty;

    // Change detection, counter look-ahead and FIFO handshake.
    always_comb begin
        in_run      = (state_q == StRun);
        is_pass     = (watch_i == PASS_PATTERN);
        cycle_nxt   = cycle_q + CW'(1);
        stable_nxt  = '0;
        if (is_pass) stable_nxt = (stable_q == STB_LIMIT) ? stable_q : stable_q + SW'(1);
        pass_hit    = in_run && is_pass && (stable_nxt == STB_LIMIT);
        timeout_hit = in_run && (cycle_nxt == CYC_LIMIT);
        push        = in_run && (watch_i != prev_q);
        pop         = evt_valid_o && evt_ready_i;
        drop        = push && fifo_full && !pop;
    end

    // Watchdog FSM with registered done decode; PASS takes priority over TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            done_q   <= 1'b0;
            prev_q   <= '0;
            cycle_q  <= '0;
            stable_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable_i) state_q <= StRun;
                end
                StRun: begin
                    cycle_q  <= cycle_nxt;
                    stable_q <= stable_nxt;
                    prev_q   <= watch_i;
                    if (pass_hit) begin
                        state_q <= StPass;
                        done_q  <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q <= StTimeout;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    // Sticky record of any event lost to a full queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else if (drop) overflow_q <= 1'b1;
    end

`ifdef SIM_MONITOR_TSTAMP_EN
    localparam int unsigned FIFO_DW = WIDTH + TSTAMP_W;

    logic [TSTAMP_W-1:0] tstamp_q;
    logic [FIFO_DW-1:0]  fifo_wdata;
    logic [FIFO_DW-1:0]  fifo_rdata;

    // Timestamp of the current RUN cycle, saturating at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tstamp_q <= '0;
        else if (in_run && (tstamp_q != '1)) tstamp_q <= tstamp_q + 32'd1;
    end

    // Pack value above timestamp.
    always_comb begin
        fifo_wdata   = {watch_i, tstamp_q};
        evt_value_o  = fifo_rdata[FIFO_DW-1 -: WIDTH];
        evt_tstamp_o = fifo_rdata[TSTAMP_W-1:0];
    end
`else
    localparam int unsigned FIFO_DW = WIDTH;

    logic [FIFO_DW-1:0] fifo_wdata;
    logic [FIFO_DW-1:0] fifo_rdata;

    // Value-only entries; timestamp port tied off.
    always_comb begin
        fifo_wdata   = watch_i;
        evt_value_o  = fifo_rdata;
        evt_tstamp_o = '0;
    end
`endif

    sim_monitor_fifo #(
        .DW    (FIFO_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid_o = !fifo_empty;
    assign state_o     = state_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_sim_monitor.sv
// Scoreboard bench for sim_monitor: three instances share stimulus, one is observed at a time.
module tb_sim_monitor;

    typedef struct packed {
        logic [3:0]  v;
        logic [31:0] ts;
    } evt_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  watch;
    logic        rdy;
    logic [1:0]  sel;

    logic        valid   [3];
    logic [3:0]  value   [3];
    logic [31:0] tstamp  [3];
    logic [1:0]  state   [3];
    logic        done    [3];
    logic        ovf     [3];

    logic        m_valid;
    logic [3:0]  m_value;
    logic [31:0] m_ts;
    logic [1:0]  m_state;
    logic        m_done;
    logic        m_ovf;

    evt_t        sb[$];
    logic [3:0]  prev_m;
    int          k_m;
    int          n_checks;
    int          n_pass;

    sim_monitor u_dut (
        .clk (clk), .reset (reset), .enable_i (enable), .watch_i (watch),
        .evt_valid_o (valid[0]), .evt_ready_i (rdy & (sel == 2'd0)), .evt_value_o (value[0]),
        .evt_tstamp_o (tstamp[0]), .state_o (state[0]), .done_o (done[0]), .overflow_o (ovf[0])
    );

    sim_monitor #(.FIFO_DEPTH (2)) u_small (
        .clk (clk), .reset (reset), .enable_i (enable), .watch_i (watch),
        .evt_valid_o (valid[1]), .evt_ready_i (rdy & (sel == 2'd1)), .evt_value_o (value[1]),
        .evt_tstamp_o (tstamp[1]), .state_o (state[1]), .done_o (done[1]), .overflow_o (ovf[1])
    );

    sim_monitor #(.TIMEOUT_CYCLES (4), .STABLE_CYCLES (4)) u_coin (
        .clk (clk), .reset (reset), .enable_i (enable), .watch_i (watch),
        .evt_valid_o (valid[2]), .evt_ready_i (rdy & (sel == 2'd2)), .evt_value_o (value[2]),
        .evt_tstamp_o (tstamp[2]), .state_o (state[2]), .done_o (done[2]), .overflow_o (ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance to the observation signals.
    always_comb begin
        m_valid = valid[sel];
        m_value = value[sel];
        m_ts    = tstamp[sel];
        m_state = state[sel];
        m_done  = done[sel];
        m_ovf   = ovf[sel];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_ts(input int k);
`ifdef SIM_MONITOR_TSTAMP_EN
        return 32'(k);
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset();
        reset  = 1'b0;
        enable = 1'b0;
        watch  = 4'h0;
        rdy    = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_run();
        enable = 1'b1;
        @(negedge clk);
        k_m    = 0;
        prev_m = 4'h0;
        check("run_entry", m_state, 2'd1);
    endtask

    // Drive one RUN cycle; rec=0 marks a change the queue is expected to drop.
    task automatic run_cycle(input logic [3:0] v, input bit rec);
        evt_t e;
        watch = v;
        if (rec && (v != prev_m)) begin
            e.v  = v;
            e.ts = exp_ts(k_m);
            sb.push_back(e);
        end
        prev_m = v;
        k_m++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        evt_t e;
        int   guard;
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            e = sb.pop_front();
            check({tag, "_valid"}, m_valid, 1'b1);
            check({tag, "_value"}, m_value, e.v);
            check({tag, "_ts"}, m_ts, e.ts);
            rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0;
            guard++;
        end
        check({tag, "_empty"}, m_valid, 1'b0);
    endtask

    initial begin
        evt_t e;
        n_checks = 0;
        n_pass   = 0;
        sel      = 2'd0;
        k_m      = 0;
        prev_m   = 4'h0;

        // Reset values and plain timeout.
        do_reset();
        check("rst_state", m_state, 2'd0);
        check("rst_done", m_done, 1'b0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_value", m_value, 4'h0);
        check("rst_ts", m_ts, 32'd0);
        check("rst_ovf", m_ovf, 1'b0);
        start_run();
        for (int i = 0; i < 249; i++) run_cycle(4'h0, 1'b1);
        check("to_not_yet", m_state, 2'd1);
        check("to_done_low", m_done, 1'b0);
        run_cycle(4'h0, 1'b1);
        check("to_state", m_state, 2'd3);
        check("to_done", m_done, 1'b1);
        check("to_no_evt", m_valid, 1'b0);
        check("to_ovf", m_ovf, 1'b0);
        run_cycle(4'h5, 1'b0);
        check("to_frozen", m_state, 2'd3);
        check("to_no_push", m_valid, 1'b0);

        // Two changes queued in order with RUN-cycle timestamps.
        do_reset();
        start_run();
        for (int k = 0; k < 12; k++) begin
            if (k == 4) check("evt_latency", m_valid, 1'b1);
            if (k == 3) check("evt_none_yet", m_valid, 1'b0);
            run_cycle((k < 3) ? 4'h0 : (k < 7) ? 4'h5 : 4'h6, 1'b1);
        end
        drain("evt");

        // PASS needs four consecutive cycles of the pattern.
        do_reset();
        start_run();
        for (int k = 0; k < 7; k++) run_cycle((k == 3) ? 4'h0 : 4'hF, 1'b1);
        check("pass_not_yet", m_state, 2'd1);
        run_cycle(4'hF, 1'b1);
        check("pass_state", m_state, 2'd2);
        check("pass_done", m_done, 1'b1);
        drain("pass_evt");

        // Depth-2 queue overflow, then push accepted alongside a pop while full.
        do_reset();
        sel = 2'd1;
        start_run();
        run_cycle(4'h1, 1'b1);
        run_cycle(4'h2, 1'b1);
        check("ovf_before", m_ovf, 1'b0);
        run_cycle(4'h3, 1'b0);
        check("ovf_set", m_ovf, 1'b1);
        e = sb.pop_front();
        check("ovf_head_value", m_value, e.v);
        check("ovf_head_ts", m_ts, e.ts);
        rdy = 1'b1;
        run_cycle(4'h4, 1'b1);
        rdy = 1'b0;
        check("ovf_sticky", m_ovf, 1'b1);
        drain("ovf_evt");

        // PASS and TIMEOUT on the same edge.
        do_reset();
        sel = 2'd2;
        start_run();
        for (int k = 0; k < 3; k++) run_cycle(4'hF, 1'b1);
        check("coin_not_yet", m_state, 2'd1);
        run_cycle(4'hF, 1'b1);
        check("coin_state", m_state, 2'd2);
        check("coin_done", m_done, 1'b1);
        drain("coin_evt");

        // Asynchronous reset mid-run with events queued.
        do_reset();
        sel = 2'd1;
        start_run();
        run_cycle(4'h1, 1'b1);
        run_cycle(4'h2, 1'b1);
        run_cycle(4'h3, 1'b0);
        check("ar_pre_valid", m_valid, 1'b1);
        check("ar_pre_ovf", m_ovf, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("ar_state", m_state, 2'd0);
        check("ar_done", m_done, 1'b0);
        check("ar_valid", m_valid, 1'b0);
        check("ar_value", m_value, 4'h0);
        check("ar_ts", m_ts, 32'd0);
        check("ar_ovf", m_ovf, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_monitor.md
# sim_monitor

Parametrised run monitor instantiated beside `soc` in simulation top-levels. It samples a watched bus, such as the LED port, every clock and queues one change event per transition. Consumers drain events through a valid/ready port. A cycle-accurate watchdog ends the run as PASS when a pass pattern holds stable, or as TIMEOUT when the cycle budget expires. It replaces ad-hoc change printing and fixed-delay timeouts with a synthesizable, checkable block.

## Interface
- `WIDTH`, 4: width of watched bus.
- `FIFO_DEPTH`, 8: event queue entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 250: RUN cycles before TIMEOUT; ≥1.
- `PASS_PATTERN`, `'1`: watched value meaning success.
- `STABLE_CYCLES`, 4: consecutive cycles `PASS_PATTERN` must hold; ≥1.
- `clk` in, 1: the single clock; all state updates on rising edge.
- `reset` in, 1: asynchronous, active-low reset. Assertion at 0 clears all state immediately; release is synchronous to `clk` by the caller.
- `enable_i` in, 1: IDLE→RUN start request.
- `watch_i` in, WIDTH: observed bus.
- `evt_valid_o` out, 1: event available.
- `evt_ready_i` in, 1: consumer accepts the event.
- `evt_value_o` out, WIDTH: new bus value.
- `evt_tstamp_o` out, 32: RUN cycle of change (see Configuration).
- `state_o` out, 2: IDLE=0, RUN=1, PASS=2, TIMEOUT=3.
- `done_o` out, 1: state is PASS or TIMEOUT.
- `overflow_o` out, 1: sticky; an event was dropped.

## Operation
- Reset values: state IDLE, `prev_q`=0, cycle counter 0, stable counter 0, FIFO empty, `evt_valid_o`=0, `evt_value_o`=0, `evt_tstamp_o`=0, `done_o`=0, `overflow_o`=0.
- IDLE: nothing is recorded and counters are held. `enable_i`=1 moves to RUN on the next edge.
- RUN, every edge:
  - The cycle counter increments. Its width is `$clog2(TIMEOUT_CYCLES+1)`. The 32-bit timestamp counter increments, saturating at 2^32−1.
  - `prev_q` is loaded with `watch_i`.
  - If `watch_i != prev_q`, push {`watch_i`, timestamp}. Because `prev_q` resets to 0, a nonzero value on the first RUN cycle is an event.
  - The stable counter increments, saturating at `STABLE_CYCLES`, while `watch_i == PASS_PATTERN`; otherwise it clears to 0.
- RUN→PASS when the stable counter would reach `STABLE_CYCLES` this edge.
- RUN→TIMEOUT when the cycle counter would reach `TIMEOUT_CYCLES` this edge.
- Both in the same edge: PASS wins.
- PASS and TIMEOUT are terminal until reset: no new pushes, counters frozen, `done_o`=1. The FIFO remains drainable.
- FIFO:
  - Pop occurs when `evt_valid_o && evt_ready_i`.
  - Push while full with no pop in the same edge: the event is dropped and `overflow_o` is set.
  - Push while full with a pop in the same edge: accepted.
  - Push and pop when empty: the pushed entry becomes visible on the next cycle; it is not bypassed.
- `evt_value_o` and `evt_tstamp_o` are stable while `evt_valid_o`=1 and not popped.
- Reset asserted mid-run aborts immediately to reset values. Queued events are lost.

## Timing
- Change sampled at edge N → `evt_valid_o`=1 after edge N, visible during cycle N+1, if the FIFO was empty.
- Timestamp of the first RUN cycle is 0.
- Terminal transition is visible on `state_o`/`done_o` in the cycle after the deciding edge.
- `done_o` is a registered decode, not combinational from `watch_i`.
- TIMEOUT asserts exactly `TIMEOUT_CYCLES` edges after entry to RUN, given no PASS.

## Configuration
- `SIM_MONITOR_TSTAMP_EN` defined: FIFO entries are WIDTH+32 bits, and `evt_tstamp_o` carries the timestamp.
- Undefined: the timestamp counter and storage are not built, entries are WIDTH bits, and `evt_tstamp_o` is tied to 0.
- The port list is identical in both builds.

## Structure
- `sim_monitor_pkg`: `mon_state_e` enum (IDLE/RUN/PASS/TIMEOUT) and `TSTAMP_W`=32.
- Sub-module `sim_monitor_fifo`: synchronous FIFO parametrised by data width and depth, with full/empty flags. It has the same `clk`/`reset` semantics.
- The top holds the FSM, the counters and change detection.

## Test plan
- Reset, `enable_i`=1, `watch_i`=0 constant, default params → TIMEOUT after 250 RUN edges; no events; `overflow_o`=0.
- `watch_i` 0→5 at RUN cycle 3, then 5→6 at cycle 7 → two events {5,3} and {6,7} in order (timestamps with macro on; 0 with it off).
- `PASS_PATTERN`=4'hF: hold 4'hF for 3 cycles, break for 1, then hold 4 cycles → PASS only after the 4th consecutive cycle; `done_o`=1.
- `FIFO_DEPTH`=2, `evt_ready_i`=0, 3 changes → 2 queued, `overflow_o`=1. A further change with a simultaneous pop while full → accepted, no new drop.
- PASS condition and timeout coincide (`TIMEOUT_CYCLES`=`STABLE_CYCLES`=4, pattern held from cycle 0) → state PASS.
- Assert `reset` mid-RUN with queued events → all outputs return to reset values immediately, without waiting for a clock edge.
